// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch path: PC update commands and the canonical NOP.
package instr_fetch_unit_pkg;

    typedef enum logic [2:0] {
        PCHold   = 3'd0,
        PCAdd4   = 3'd1,
        PCAddImm = 3'd2,
        PCSetImm = 3'd3
    } pc_op_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted when a pop frees a slot the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & (count != '0) & ~flush;
    assign do_push = push & ((count != FULL_COUNT) | do_pop) & ~flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: issues PC-addressed memory requests under a credit limit and queues PC-tagged
// instructions for decode, discarding in-flight responses after a redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_rdata,
    output logic [2:0]  pc_op,
    output logic [31:0] pc_wdata,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);

    logic [CW-1:0] inflight;
    logic [CW-1:0] drop;
    logic [CW-1:0] q_count;
    logic [CW-1:0] a_count;
    logic [CW:0]   occupancy;
    logic          redirect;
    logic          credit;
    logic          handshake;
    logic          resp_drop;
    logic          q_push;
    logic          q_pop;
    logic [31:0]   a_pc;
    logic [63:0]   q_head;

    // Outputs are held quiet while reset is asserted, not just after the first edge.
    assign redirect       = redirect_valid & ~reset;
    assign occupancy      = {1'b0, inflight} + {1'b0, q_count};
    assign credit         = ~reset & (occupancy < CREDIT_LIMIT);
    assign imem_req_valid = credit & ~redirect_valid;
    assign imem_req_addr  = pc_rdata;
    assign handshake      = imem_req_valid & imem_req_ready;

    always_comb begin
        pc_op    = PCHold;
        pc_wdata = '0;
        if (redirect) begin
            pc_op    = PCSetImm;
            pc_wdata = redirect_target;
        end else if (handshake) begin
            pc_op = PCAdd4;
        end
    end

    assign resp_drop = (drop != '0) | redirect_valid;
    assign q_push    = imem_resp_valid & ~resp_drop;
    assign q_pop     = out_valid & out_ready;

    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_addr_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .push  (handshake),
        .wdata (pc_rdata),
        .pop   (imem_resp_valid),
        .rdata (a_pc),
        .count (a_count)
    );

    fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (q_push),
        .wdata ({imem_resp_data, a_pc}),
        .pop   (q_pop),
        .rdata (q_head),
        .count (q_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight + CW'(handshake) - CW'(imem_resp_valid);
            // Everything still outstanding after this cycle's response belongs to the old stream.
            if (redirect_valid)
                drop <= inflight - CW'(imem_resp_valid);
            else if (imem_resp_valid && drop != '0)
                drop <= drop - 1'b1;
        end
    end

    assign out_valid = (q_count != '0);
    assign out_instr = q_head[63:32];
    assign out_pc    = q_head[31:0];

    a_resp_needs_inflight: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> (inflight != '0));
    a_q_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(q_push && q_count == FULL_COUNT && !q_pop));
    a_drop_bounded: assert property (@(posedge clk) disable iff (reset)
        drop <= inflight);
    a_addr_tracks_inflight: assert property (@(posedge clk) disable iff (reset)
        a_count == inflight);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC register model and a fixed-latency in-order memory model.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_rdata;
    logic [2:0]  pc_op;
    logic [31:0] pc_wdata;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 1;
    int cyc;

    instr_fetch_unit #(.DEPTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_rdata        (pc_rdata),
        .pc_op           (pc_op),
        .pc_wdata        (pc_wdata),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        if (a == 32'h0)      return NOP;
        else if (a == 32'h8) return 32'h0020_0113;
        else                 return 32'h0000_0093 | ((a >> 2) << 20);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) pc_rdata <= '0;
        else if (pc_op == PCAdd4) pc_rdata <= pc_rdata + 32'd4;
        else if (pc_op == PCSetImm) pc_rdata <= pc_wdata;
    end

    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend.delete();
            imem_resp_valid <= 1'b0;
            imem_resp_data  <= '0;
            cyc             <= 0;
        end else begin
            cyc <= cyc + 1;
            if (imem_req_valid && imem_req_ready) pend.push_back('{imem_req_addr, cyc + lat});
            if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= instr_of(pend[0].addr);
                pend.pop_front();
            end else begin
                imem_resp_valid <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_out(input string name, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: out_valid never rose within %0d cycles", name, budget);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          mem_rdy;
        bit          o_rdy;
        bit          e_req;
        logic [31:0] e_addr;
        logic [2:0]  e_op;
        bit          e_ov;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[20];

    initial begin
        // Test 1: streaming with ready memory and decode
        vecs[0]  = '{1, 1, 1, 1, 32'h0,  PCAdd4, 0, 32'h0,         32'h0};
        vecs[1]  = '{0, 1, 1, 1, 32'h4,  PCAdd4, 0, 32'h0,         32'h0};
        vecs[2]  = '{0, 1, 1, 0, 32'h8,  PCHold, 1, 32'h0000_0013, 32'h0};
        vecs[3]  = '{0, 1, 1, 1, 32'h8,  PCAdd4, 1, 32'h0010_0093, 32'h4};
        vecs[4]  = '{0, 1, 1, 1, 32'hC,  PCAdd4, 0, 32'h0,         32'h0};
        vecs[5]  = '{0, 1, 1, 0, 32'h10, PCHold, 1, 32'h0020_0113, 32'h8};
        // Test 2: decode stalled, credit exhausted, then drained
        vecs[6]  = '{1, 1, 0, 1, 32'h0,  PCAdd4, 0, 32'h0,         32'h0};
        vecs[7]  = '{0, 1, 0, 1, 32'h4,  PCAdd4, 0, 32'h0,         32'h0};
        vecs[8]  = '{0, 1, 0, 0, 32'h8,  PCHold, 1, 32'h0000_0013, 32'h0};
        vecs[9]  = '{0, 1, 0, 0, 32'h8,  PCHold, 1, 32'h0000_0013, 32'h0};
        vecs[10] = '{0, 1, 1, 0, 32'h8,  PCHold, 1, 32'h0000_0013, 32'h0};
        vecs[11] = '{0, 1, 1, 1, 32'h8,  PCAdd4, 1, 32'h0010_0093, 32'h4};
        vecs[12] = '{0, 1, 1, 1, 32'hC,  PCAdd4, 0, 32'h0,         32'h0};
        vecs[13] = '{0, 1, 1, 0, 32'h10, PCHold, 1, 32'h0020_0113, 32'h8};
        // Test 3: memory not ready for three cycles
        vecs[14] = '{1, 0, 1, 1, 32'h0,  PCHold, 0, 32'h0,         32'h0};
        vecs[15] = '{0, 0, 1, 1, 32'h0,  PCHold, 0, 32'h0,         32'h0};
        vecs[16] = '{0, 0, 1, 1, 32'h0,  PCHold, 0, 32'h0,         32'h0};
        vecs[17] = '{0, 1, 1, 1, 32'h0,  PCAdd4, 0, 32'h0,         32'h0};
        vecs[18] = '{0, 1, 1, 1, 32'h4,  PCAdd4, 0, 32'h0,         32'h0};
        vecs[19] = '{0, 1, 1, 0, 32'h8,  PCHold, 1, 32'h0000_0013, 32'h0};

        reset           = 1'b1;
        imem_req_ready  = 1'b1;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        #2;
        chk("rst req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst pc_op", 32'(pc_op), 32'(PCHold));
        redirect_valid  = 1'b1;
        redirect_target = 32'h55;
        #1;
        chk("rst redirect pc_op", 32'(pc_op), 32'(PCHold));
        chk("rst redirect pc_wdata", pc_wdata, 32'h0);
        redirect_valid = 1'b0;

        lat = 1;
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].rst) do_reset();
            else @(negedge clk);
            imem_req_ready = vecs[i].mem_rdy;
            out_ready      = vecs[i].o_rdy;
            #1;
            chk($sformatf("row%0d req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_req));
            chk($sformatf("row%0d req_addr", i), imem_req_addr, vecs[i].e_addr);
            chk($sformatf("row%0d pc_op", i), 32'(pc_op), 32'(vecs[i].e_op));
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                chk($sformatf("row%0d out_instr", i), out_instr, vecs[i].e_instr);
                chk($sformatf("row%0d out_pc", i), out_pc, vecs[i].e_pc);
            end
        end

        // Test 4: redirect with two stale fetches in flight (3-cycle memory)
        lat = 3;
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        repeat (2) @(negedge clk);
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        #1;
        chk("t4 pc_op", 32'(pc_op), 32'(PCSetImm));
        chk("t4 pc_wdata", pc_wdata, 32'h100);
        chk("t4 req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("t4 q empty", 32'(out_valid), 32'd0);
        chk("t4 no credit", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("t4 refetch valid", 32'(imem_req_valid), 32'd1);
        chk("t4 refetch addr", imem_req_addr, 32'h100);
        wait_out("t4 wait", 30);
        chk("t4 out_pc", out_pc, 32'h100);
        chk("t4 out_instr", out_instr, 32'h0400_0093);

        // Test 5: redirect coincides with a response while Q holds one entry
        lat = 2;
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b0;
        repeat (3) @(negedge clk);
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        #1;
        chk("t5 q held", 32'(out_valid), 32'd1);
        chk("t5 q head pc", out_pc, 32'h0);
        chk("t5 pc_op", 32'(pc_op), 32'(PCSetImm));
        chk("t5 pc_wdata", pc_wdata, 32'h200);
        chk("t5 no issue", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("t5 q flushed", 32'(out_valid), 32'd0);
        chk("t5 refetch valid", 32'(imem_req_valid), 32'd1);
        chk("t5 refetch addr", imem_req_addr, 32'h200);
        out_ready = 1'b1;
        wait_out("t5 wait", 30);
        chk("t5 out_pc", out_pc, 32'h200);
        chk("t5 out_instr", out_instr, 32'h0800_0093);

        // Test 6: reset mid-stream with Q full and nothing in flight
        lat = 1;
        do_reset();
        imem_req_ready = 1'b1;
        out_ready      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t6 q full", 32'(out_valid), 32'd1);
        chk("t6 no credit", 32'(imem_req_valid), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6 rst out_valid", 32'(out_valid), 32'd0);
        chk("t6 rst req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6 rst pc_op", 32'(pc_op), 32'(PCHold));
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("t6 restart valid", 32'(imem_req_valid), 32'd1);
        chk("t6 restart addr", imem_req_addr, 32'h0);
        chk("t6 restart pc_op", 32'(pc_op), 32'(PCAdd4));
        chk("t6 restart out_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Drives the program counter's control inputs (pc_op, pc_wdata) and consumes its output (pc_rdata) to issue instruction-memory fetches. Tracks in-flight requests and buffers returned instructions, tagged with their PC, toward decode. Handles redirects (branch/jump/trap targets) from execute, discarding responses already in flight.

Parameters:
DEPTH, 2, output queue depth and maximum in-flight fetches; power of 2, at least 2.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
pc_rdata  in  32  current PC, which is the address of the next fetch
pc_op  out  3  PC update command
pc_wdata  out  32  PC write data (redirect target)
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  32  fetch address
imem_req_ready  in  1  memory accepts request
imem_resp_valid  in  1  instruction returned; always accepted, never back-pressured
imem_resp_data  in  32  returned instruction
redirect_valid  in  1  flush and redirect, single-cycle pulse
redirect_target  in  32  absolute redirect address
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts
out_instr  out  32  instruction
out_pc  out  32  address of out_instr

Behaviour:
- Reset is asynchronous and active-high on clk. All counters and queues clear. During and after reset: imem_req_valid=0, out_valid=0, pc_op=PCHold, pc_wdata=0. Instruction memory shares this reset, so no responses arrive from before reset.
- State:
  - inflight count I (0..DEPTH).
  - drop count D (0..I).
  - address FIFO A (DEPTH entries): PCs of in-flight requests.
  - output queue Q (DEPTH entries): {instr, pc} pairs, occupancy C.
- Credit rule: issue is allowed when I + C < DEPTH. Every response is therefore guaranteed a slot in Q.
- Request signals:
  - imem_req_valid = credit & ~redirect_valid.
  - imem_req_addr = pc_rdata.
  - A request counts only when valid and ready are high in the same cycle. The memory tolerates valid dropping without a handshake.
- pc_op is combinational, priority high to low:
  - redirect_valid: PCSetImm, pc_wdata = redirect_target.
  - request handshake: PCAdd4.
  - otherwise: PCHold.
  - pc_wdata = 0 when not redirecting.
- On handshake: push pc_rdata into A; I += 1.
- On imem_resp_valid: pop A; I -= 1.
  - If D > 0, or redirect_valid is high the same cycle, discard the response. D -= 1 when D > 0.
  - Otherwise push {imem_resp_data, popped pc} into Q.
- Redirect cycle:
  - Q cleared; any Q pop that cycle is ignored.
  - No issue that cycle.
  - D_next = I - resp.
  - New fetches start the next cycle at the redirect target.
- Output: out_valid = (C != 0). out_instr/out_pc come from the Q head. Pop on out_valid & out_ready.
- Latency: response cycle N → out_valid at N+1 (Q is registered). Q may push and pop in the same cycle, including when Q is full and a pop frees a slot.
- Memory response latency is arbitrary (≥1 cycle) and responses return in order.
- Pointers wrap modulo DEPTH. Counters need width clog2(DEPTH)+1.
- Assertions:
  - No response when I == 0.
  - Q never overflows.
  - D ≤ I.

Decomposition:
- Shared defines package holds the pc_op encodings: PCHold=3'd0, PCAdd4=3'd1, PCAddImm=3'd2, PCSetImm=3'd3 (PCAddImm is unused here). It also holds the NOP constant 32'h00000013 for benches.
- One sub-module: fetch_fifo (parameterised width/depth synchronous FIFO with flush). Instantiate it twice: 32-bit for A, 64-bit for Q.

Test Plan:
1. Reset, memory ready=1 with 1-cycle response returning 0x13, 0x00100093, 0x00200113, out_ready=1 → pc_op=PCAdd4 on each issue; outputs {0x13,pc 0}, {0x00100093,pc 4}, {0x00200113,pc 8} in order, first out_valid 2 cycles after first handshake.
2. DEPTH=2, out_ready=0 → after 2 issues (pc 0, 4) imem_req_valid=0 and pc_op=PCHold; raise out_ready → one pop per cycle, then issue resumes at pc 8.
3. imem_req_ready=0 for 3 cycles → imem_req_valid=1, addr stable at pc_rdata, pc_op=PCHold; first ready cycle gives PCAdd4.
4. Two requests in flight (pc 0, 4), redirect_target=0x100 → pc_op=PCSetImm, pc_wdata=0x100, Q empty, both stale responses dropped, next out_pc=0x100.
5. Redirect in the same cycle as a response, with Q holding one entry → response and Q entry discarded, D = I - 1, no issue that cycle.
6. Assert reset mid-stream with Q full and I=0 → out_valid=0 and imem_req_valid=0 immediately; after release, fetch restarts at pc 0 with PCAdd4.
